ddr_cmd_issue: RTL
==================

DDR_CMD_ISSUE -- requirements
Module: ddr_cmd_issue

Interface
REQ-001 SHALL have parameter BA_WIDTH, default 3, DDR bank address width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, DDR row/column address width.
REQ-003 SHALL have parameters T_RCD=3, T_RP=3, T_RAS=8, T_RFC=20, in clk cycles, each at least 1.
REQ-004 SHALL have clk  input  1  sole clock; all logic samples on its rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have req_valid input 1, req_ready output 1, req_cmd input 3, req_ba input BA_WIDTH, req_addr input ADDR_WIDTH.
REQ-007 SHALL use req_cmd encoding 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF; 6 and 7 are illegal.
REQ-008 SHALL have outputs cke, cs_n, ras_n, cas_n, we_n (1 each), ba (BA_WIDTH), addr (ADDR_WIDTH), all registered, feeding the DDRPHY command pins.
REQ-009 SHALL have outputs bank_open (2^BA_WIDTH, one bit per bank) and cmd_err (1, single-cycle pulse).

Function
REQ-010 SHALL complete a handshake when req_valid and req_ready are both 1 in the same cycle.
REQ-011 SHALL drive an accepted command on the pins in the cycle after the handshake, giving a latency of 1.
REQ-012 SHALL drive NOP (cs_n=0, ras_n=1, cas_n=1, we_n=1, ba/addr held) in every cycle without a fresh issue.
REQ-013 SHALL encode {ras_n, cas_n, we_n} as: ACT 011, RD 101, WR 100, PRE 010, REF 001; cs_n is 0 for all of them.
REQ-014 SHALL track per-bank counters rcd_cnt, ras_cnt, rp_cnt and a global rfc_cnt; each decrements by 1 per cycle and saturates at 0.
REQ-015 SHALL, on ACT accept: set bank_open[ba]; load rcd_cnt[ba]=T_RCD-1 and ras_cnt[ba]=T_RAS-1.
REQ-016 SHALL, on PRE accept: clear bank_open[ba]; load rp_cnt[ba]=T_RP-1.
REQ-017 SHALL, on REF accept: load rfc_cnt=T_RFC-1.
REQ-018 SHALL hold req_ready=1 for an ACT when rp_cnt[ba]==0 and rfc_cnt==0.
REQ-019 SHALL hold req_ready=1 for an RD or WR when rcd_cnt[ba]==0.
REQ-020 SHALL hold req_ready=1 for a PRE when ras_cnt[ba]==0.
REQ-021 SHALL hold req_ready=1 for a REF when all rp_cnt are 0 and rfc_cnt==0.
REQ-022 SHALL hold req_ready=1 for a NOP or an illegal command.
REQ-023 SHALL hold req_ready=0 whenever cke=0.
REQ-024 SHALL treat as illegal: ACT to an open bank, RD/WR to a closed bank, PRE to a closed bank, REF with any bank open, and codes 6/7.
REQ-025 SHALL, on accepting an illegal command, drive NOP, change no state, and pulse cmd_err=1 in the next cycle.
REQ-026 SHALL evaluate legality before timing, so an illegal command is never stalled.
REQ-027 SHALL compute req_ready combinationally from the current request and registered state, without depending on req_ready itself.
REQ-028 SHALL let a counter load and a same-bank decrement coincide, with the load winning.
REQ-029 SHALL let different banks' counters run independently, so a request to bank B is never stalled by bank A's timing.

Reset
REQ-030 SHALL, while rst_n=0, force cke=0, cs_n=1, ras_n=1, cas_n=1, we_n=1, ba=0, addr=0, bank_open=0, cmd_err=0, and all counters to 0.
REQ-031 SHALL set cke=1 on the first clk edge after rst_n deasserts, with cs_n=0 and NOP, so the first handshake is possible one cycle later.
REQ-032 SHALL, on reset assertion mid-operation, immediately close all banks and discard any command in flight; the bench then sees the reset values.

Verification
REQ-033 SHALL pass: ACT bank2 row 0x155 accepted at N -> pins show ras_n/cas_n/we_n=011, ba=2, addr=0x155 at N+1; bank_open[2]=1.
REQ-034 SHALL pass: RD bank2 offered from N+1 -> req_ready=0 at N+1..N+2, accepted at N+3, RD on pins at N+4.
REQ-035 SHALL pass: PRE bank2 offered after ACT at N -> stalled until N+8; then ACT bank2 accepted no earlier than N+11.
REQ-036 SHALL pass: REF with all banks closed at M -> next ACT stalled until M+20; RD to closed bank0 -> NOP on pins, cmd_err=1 for one cycle, no stall.
REQ-037 SHALL pass: ACT bank0 at N, ACT bank1 at N+1 -> both accepted back-to-back; RD bank1 accepted at N+4.
REQ-038 SHALL pass: rst_n pulsed low with banks 0 and 3 open -> bank_open=0 and cke=0 asynchronously; cke=1 one edge after release.

Source files
------------

// File: rtl/ddr_cmd_issue.sv
// DDR command issue stage: accepts one command per handshake, enforces per-bank
// tRCD/tRAS/tRP and global tRFC timing, rejects illegal commands with a one-cycle
// cmd_err pulse, and drives registered command pins toward the DDR PHY.
module ddr_cmd_issue #(
    parameter int BA_WIDTH   = 3,
    parameter int ADDR_WIDTH = 14,
    parameter int T_RCD      = 3,
    parameter int T_RP       = 3,
    parameter int T_RAS      = 8,
    parameter int T_RFC      = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_cmd,
    input  logic [BA_WIDTH-1:0]       req_ba,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    output logic                      cke,
    output logic                      cs_n,
    output logic                      ras_n,
    output logic                      cas_n,
    output logic                      we_n,
    output logic [BA_WIDTH-1:0]       ba,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [(1<<BA_WIDTH)-1:0]  bank_open,
    output logic                      cmd_err
);

    localparam int NUM_BANKS = 1 << BA_WIDTH;

    // Counter width sized for the largest timing parameter minus one.
    localparam int T_MAX_A = (T_RCD > T_RP)   ? T_RCD   : T_RP;
    localparam int T_MAX_B = (T_RAS > T_RFC)  ? T_RAS   : T_RFC;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] RCD_LOAD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] RP_LOAD  = CW'(T_RP  - 1);
    localparam logic [CW-1:0] RAS_LOAD = CW'(T_RAS - 1);
    localparam logic [CW-1:0] RFC_LOAD = CW'(T_RFC - 1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    // Registered pin state
    logic                  r_cke;
    logic                  r_cs_n;
    logic [2:0]            r_rcw;
    logic [BA_WIDTH-1:0]   r_ba;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NUM_BANKS-1:0]  r_bank_open;
    logic                  r_cmd_err;
    logic [CW-1:0]         r_rfc_cnt;

    // Per-bank "counter has expired" flags gathered from the bank slices
    logic [NUM_BANKS-1:0]  w_rcd_zero;
    logic [NUM_BANKS-1:0]  w_ras_zero;
    logic [NUM_BANKS-1:0]  w_rp_zero;
    logic                  w_rfc_zero;

    logic                  w_sel_open;
    logic                  w_illegal;
    logic                  w_timing_ok;
    logic                  w_accept;
    logic                  w_issue;
    logic [2:0]            w_rcw;

    assign w_rfc_zero = (r_rfc_cnt == '0);
    assign w_sel_open = r_bank_open[req_ba];

    // Legality check: illegal requests are always accepted so they never stall.
    always_comb begin
        w_illegal = 1'b0;
        case (req_cmd)
            CMD_NOP: w_illegal = 1'b0;
            CMD_ACT: w_illegal = w_sel_open;
            CMD_RD,
            CMD_WR,
            CMD_PRE: w_illegal = ~w_sel_open;
            CMD_REF: w_illegal = |r_bank_open;
            default: w_illegal = 1'b1;
        endcase
    end

    // Timing check for the addressed bank (or all banks for REF).
    always_comb begin
        w_timing_ok = 1'b1;
        case (req_cmd)
            CMD_ACT: w_timing_ok = w_rp_zero[req_ba] & w_rfc_zero;
            CMD_RD,
            CMD_WR:  w_timing_ok = w_rcd_zero[req_ba];
            CMD_PRE: w_timing_ok = w_ras_zero[req_ba];
            CMD_REF: w_timing_ok = (&w_rp_zero) & w_rfc_zero;
            default: w_timing_ok = 1'b1;
        endcase
    end

    assign req_ready = r_cke & (w_illegal | w_timing_ok);
    assign w_accept  = req_valid & req_ready;
    assign w_issue   = w_accept & ~w_illegal & (req_cmd != CMD_NOP);

    // Pin encoding of {ras_n, cas_n, we_n}; anything else is a NOP.
    always_comb begin
        w_rcw = 3'b111;
        case (req_cmd)
            CMD_ACT: w_rcw = 3'b011;
            CMD_RD:  w_rcw = 3'b101;
            CMD_WR:  w_rcw = 3'b100;
            CMD_PRE: w_rcw = 3'b010;
            CMD_REF: w_rcw = 3'b001;
            default: w_rcw = 3'b111;
        endcase
    end

    // Command pins: issue the accepted command one cycle after handshake, else NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cke     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_rcw     <= 3'b111;
            r_ba      <= '0;
            r_addr    <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cke     <= 1'b1;
            r_cs_n    <= 1'b0;
            r_cmd_err <= w_accept & w_illegal;
            if (w_issue) begin
                r_rcw  <= w_rcw;
                r_ba   <= req_ba;
                r_addr <= req_addr;
            end else begin
                r_rcw  <= 3'b111;
            end
        end
    end

    // Open-row bookkeeping: ACT opens, PRE closes the addressed bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_open <= '0;
        end else if (w_issue && req_cmd == CMD_ACT) begin
            r_bank_open[req_ba] <= 1'b1;
        end else if (w_issue && req_cmd == CMD_PRE) begin
            r_bank_open[req_ba] <= 1'b0;
        end
    end

    // Global refresh recovery counter; a REF load wins over the decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rfc_cnt <= '0;
        end else if (w_issue && req_cmd == CMD_REF) begin
            r_rfc_cnt <= RFC_LOAD;
        end else if (r_rfc_cnt != '0) begin
            r_rfc_cnt <= r_rfc_cnt - 1'b1;
        end
    end

    // One independent set of timing counters per bank.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic          w_hit;
            logic [CW-1:0] r_rcd_cnt;
            logic [CW-1:0] r_ras_cnt;
            logic [CW-1:0] r_rp_cnt;

            assign w_hit = w_issue && (req_ba == BA_WIDTH'(gi));

            // ACT loads tRCD/tRAS, PRE loads tRP; otherwise count down to zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rcd_cnt <= '0;
                    r_ras_cnt <= '0;
                    r_rp_cnt  <= '0;
                end else begin
                    if (w_hit && req_cmd == CMD_ACT) begin
                        r_rcd_cnt <= RCD_LOAD;
                        r_ras_cnt <= RAS_LOAD;
                    end else begin
                        if (r_rcd_cnt != '0) r_rcd_cnt <= r_rcd_cnt - 1'b1;
                        if (r_ras_cnt != '0) r_ras_cnt <= r_ras_cnt - 1'b1;
                    end
                    if (w_hit && req_cmd == CMD_PRE) begin
                        r_rp_cnt <= RP_LOAD;
                    end else if (r_rp_cnt != '0) begin
                        r_rp_cnt <= r_rp_cnt - 1'b1;
                    end
                end
            end

            assign w_rcd_zero[gi] = (r_rcd_cnt == '0);
            assign w_ras_zero[gi] = (r_ras_cnt == '0);
            assign w_rp_zero[gi]  = (r_rp_cnt  == '0);
        end
    endgenerate

    assign cke       = r_cke;
    assign cs_n      = r_cs_n;
    assign ras_n     = r_rcw[2];
    assign cas_n     = r_rcw[1];
    assign we_n      = r_rcw[0];
    assign ba        = r_ba;
    assign addr      = r_addr;
    assign bank_open = r_bank_open;
    assign cmd_err   = r_cmd_err;

endmodule
